fpu_operand_unpack: RTL and testbench

Issue-side front end for the single-precision add/sub datapath. It accepts two packed IEEE-754 binary32 operands, the operation and the rounding mode over a valid/ready handshake. It unpacks and classifies each operand into sign, exponent, 24-bit significand with hidden bit, and zero/inf/NaN flags. It delivers these fields, pipelined, to the arithmetic unit through a second valid/ready interface. Back-pressure is fully supported, with no bubbles under continuous streaming.

---
 rtl/fpu_operand_unpack.sv | 225 ++++++++++++++++++++++
 tb/tb_fpu_operand_unpack.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_operand_unpack.sv
// Operand unpack/classify front end for the binary32 add/sub datapath.
// Optional FCLASS mask output on operand A is enabled by defining FPU_UNPACK_FCLASS_EN.
module fpu_operand_unpack #(
    parameter int unsigned REG_INPUT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    input  logic [2:0]  in_rm,
`ifdef FPU_UNPACK_FCLASS_EN
    output logic [9:0]  class_A,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sign_A,
    output logic        sign_B,
    output logic [7:0]  exp_A,
    output logic [7:0]  exp_B,
    output logic [23:0] sig_A,
    output logic [23:0] sig_B,
    output logic        isZeroA,
    output logic        isZeroB,
    output logic        isInfA,
    output logic        isInfB,
    output logic        isNaNA,
    output logic        isNaNB,
    output logic        isSignaling,
    output logic        sub_op,
    output logic [2:0]  rounding_mode,
    output logic        rm_invalid
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned SIG_W   = FRAC_W + 1;
    localparam int unsigned RM_W    = 3;
    localparam int unsigned CLASS_W = 10;

    localparam logic [EXP_W-1:0] EXP_MAX  = '1;
    localparam logic [RM_W-1:0]  RM_LEGAL = 3'b100;

    typedef struct packed {
        logic [WORD_W-1:0] a;
        logic [WORD_W-1:0] b;
        logic              sub;
        logic [RM_W-1:0]   rm;
    } raw_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
        logic             zero;
        logic             inf;
        logic             nan;
    } opnd_t;

    typedef struct packed {
        opnd_t             a;
        opnd_t             b;
        logic              signaling;
        logic              sub;
        logic [RM_W-1:0]   rm;
        logic              rm_invalid;
`ifdef FPU_UNPACK_FCLASS_EN
        logic [CLASS_W-1:0] cls;
`endif
    } bundle_t;

    // Per-field decode only; subnormals keep exp=0 and a clear hidden bit.
    function automatic opnd_t unpack(input logic [WORD_W-1:0] x);
        opnd_t o;
        logic  frac_nz;
        frac_nz = |x[FRAC_W-1:0];
        o.sign  = x[WORD_W-1];
        o.exp   = x[WORD_W-2:FRAC_W];
        o.sig   = {(x[WORD_W-2:FRAC_W] != '0), x[FRAC_W-1:0]};
        o.zero  = (x[WORD_W-2:FRAC_W] == '0) && !frac_nz;
        o.inf   = (x[WORD_W-2:FRAC_W] == EXP_MAX) && !frac_nz;
        o.nan   = (x[WORD_W-2:FRAC_W] == EXP_MAX) && frac_nz;
        return o;
    endfunction

`ifdef FPU_UNPACK_FCLASS_EN
    // One-hot RISC-V FCLASS mask from an already unpacked operand.
    function automatic logic [CLASS_W-1:0] fclass(input opnd_t o);
        logic [CLASS_W-1:0] m;
        logic               subn;
        m    = '0;
        subn = (o.exp == '0) && !o.zero;
        if (o.nan) begin
            if (o.sig[FRAC_W-1]) m[9] = 1'b1;
            else                 m[8] = 1'b1;
        end else if (o.inf) begin
            if (o.sign) m[0] = 1'b1;
            else        m[7] = 1'b1;
        end else if (o.zero) begin
            if (o.sign) m[3] = 1'b1;
            else        m[4] = 1'b1;
        end else if (subn) begin
            if (o.sign) m[2] = 1'b1;
            else        m[5] = 1'b1;
        end else begin
            if (o.sign) m[1] = 1'b1;
            else        m[6] = 1'b1;
        end
        return m;
    endfunction
`endif

    logic    s2_valid_q, s2_valid_d;
    bundle_t s2_data_q, s2_data_d;
    logic    s2_load;
    logic    in_fire;
    logic    src_valid;
    raw_t    src_raw;
    bundle_t bundle_c;

    assign s2_load = !s2_valid_q || out_ready;
    assign in_fire = in_valid && in_ready;

    if (REG_INPUT != 0) begin : g_s1
        logic s1_valid_q, s1_valid_d;
        raw_t s1_raw_q, s1_raw_d;

        // No skid buffer: readiness follows out_ready through S2 combinationally.
        assign in_ready  = !reset && !flush && (!s1_valid_q || s2_load);
        assign src_valid = s1_valid_q;
        assign src_raw   = s1_raw_q;

        always_comb begin
            s1_valid_d = s1_valid_q;
            s1_raw_d   = s1_raw_q;
            if (flush) begin
                s1_valid_d = 1'b0;
            end else if (in_fire) begin
                s1_valid_d = 1'b1;
                s1_raw_d   = {in_a, in_b, in_sub, in_rm};
            end else if (s2_load) begin
                s1_valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_valid_q <= 1'b0;
                s1_raw_q   <= '0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s1_raw_q   <= s1_raw_d;
            end
        end
    end else begin : g_bypass
        assign in_ready  = !reset && !flush && s2_load;
        assign src_valid = in_fire;
        assign src_raw   = {in_a, in_b, in_sub, in_rm};
    end

    // Classify whatever feeds S2 (S1 contents or the raw inputs).
    always_comb begin
        bundle_c            = '0;
        bundle_c.a          = unpack(src_raw.a);
        bundle_c.b          = unpack(src_raw.b);
        bundle_c.signaling  = (bundle_c.a.nan && !bundle_c.a.sig[FRAC_W-1]) ||
                              (bundle_c.b.nan && !bundle_c.b.sig[FRAC_W-1]);
        bundle_c.sub        = src_raw.sub;
        bundle_c.rm         = src_raw.rm;
        bundle_c.rm_invalid = (src_raw.rm > RM_LEGAL);
`ifdef FPU_UNPACK_FCLASS_EN
        bundle_c.cls        = fclass(bundle_c.a);
`endif
    end

    // S2 only reloads when empty or draining, so stalled outputs hold.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s2_load) begin
            s2_valid_d = src_valid;
            if (src_valid) begin
                s2_data_d = bundle_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid     = s2_valid_q;
    assign sign_A        = s2_data_q.a.sign;
    assign exp_A         = s2_data_q.a.exp;
    assign sig_A         = s2_data_q.a.sig;
    assign isZeroA       = s2_data_q.a.zero;
    assign isInfA        = s2_data_q.a.inf;
    assign isNaNA        = s2_data_q.a.nan;
    assign sign_B        = s2_data_q.b.sign;
    assign exp_B         = s2_data_q.b.exp;
    assign sig_B         = s2_data_q.b.sig;
    assign isZeroB       = s2_data_q.b.zero;
    assign isInfB        = s2_data_q.b.inf;
    assign isNaNB        = s2_data_q.b.nan;
    assign isSignaling   = s2_data_q.signaling;
    assign sub_op        = s2_data_q.sub;
    assign rounding_mode = s2_data_q.rm;
    assign rm_invalid    = s2_data_q.rm_invalid;
`ifdef FPU_UNPACK_FCLASS_EN
    assign class_A       = s2_data_q.cls;
`endif

endmodule

// File: tb/tb_fpu_operand_unpack.sv
// Directed bench for fpu_operand_unpack with an occupancy/queue reference model.
module tb_fpu_operand_unpack;

    localparam int unsigned REG = 1;
    localparam int LAT = (REG != 0) ? 2 : 1;
    localparam int VW  = 88;

    logic        clk;
    logic        reset, flush, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b;
    logic [2:0]  in_rm, rounding_mode;
    logic        sign_A, sign_B, isZeroA, isZeroB, isInfA, isInfB, isNaNA, isNaNB;
    logic        isSignaling, sub_op, rm_invalid;
    logic [7:0]  exp_A, exp_B;
    logic [23:0] sig_A, sig_B;
    logic [9:0]  cls_dut;
`ifdef FPU_UNPACK_FCLASS_EN
    logic [9:0]  class_A;
    assign cls_dut = class_A;
`else
    assign cls_dut = '0;
`endif

    fpu_operand_unpack #(.REG_INPUT(REG)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_rm(in_rm),
`ifdef FPU_UNPACK_FCLASS_EN
        .class_A(class_A),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sign_A(sign_A), .sign_B(sign_B), .exp_A(exp_A), .exp_B(exp_B),
        .sig_A(sig_A), .sig_B(sig_B), .isZeroA(isZeroA), .isZeroB(isZeroB),
        .isInfA(isInfA), .isInfB(isInfB), .isNaNA(isNaNA), .isNaNB(isNaNB),
        .isSignaling(isSignaling), .sub_op(sub_op),
        .rounding_mode(rounding_mode), .rm_invalid(rm_invalid)
    );

    logic [VW-1:0] dut_vec;
    assign dut_vec = {sign_A, exp_A, sig_A, isZeroA, isInfA, isNaNA,
                      sign_B, exp_B, sig_B, isZeroB, isInfB, isNaNB,
                      isSignaling, sub_op, rounding_mode, rm_invalid, cls_dut};

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [2:0]  rm;
        int          t;
    } ent_t;

    ent_t q[$];
    int   n_chk, n_err, n_dut_out, cyc;
    logic rst_seen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Operand fields from magnitude comparisons on the IEEE encoding.
    function automatic logic [35:0] op_model(input logic [31:0] x);
        logic [31:0] mag;
        logic [7:0]  e;
        logic [23:0] s;
        mag = x & 32'h7FFF_FFFF;
        e   = x[30:23];
        s   = 24'(x & 32'h007F_FFFF) | ((e != 8'd0) ? 24'h80_0000 : 24'h0);
        return {x[31], e, s, mag == 32'h0, mag == 32'h7F80_0000, mag > 32'h7F80_0000};
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        logic [31:0] mag;
        mag = x & 32'h7FFF_FFFF;
        return (mag > 32'h7F80_0000) && (mag < 32'h7FC0_0000);
    endfunction

    function automatic logic [9:0] class_model(input logic [31:0] x);
        logic [31:0] mag;
        int          idx;
        mag = x & 32'h7FFF_FFFF;
        if (mag >= 32'h7FC0_0000)      idx = 9;
        else if (mag > 32'h7F80_0000)  idx = 8;
        else if (mag == 32'h7F80_0000) idx = x[31] ? 0 : 7;
        else if (mag == 32'h0)         idx = x[31] ? 3 : 4;
        else if (mag < 32'h0080_0000)  idx = x[31] ? 2 : 5;
        else                           idx = x[31] ? 1 : 6;
        return 10'(1 << idx);
    endfunction

    function automatic logic [VW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                            input logic sub, input logic [2:0] rm);
        logic [9:0] c;
`ifdef FPU_UNPACK_FCLASS_EN
        c = class_model(a);
`else
        c = 10'h0;
`endif
        return {op_model(a), op_model(b), is_snan(a) || is_snan(b), sub, rm, rm > 3'd4, c};
    endfunction

    // Reference: FIFO of accepted bundles; the head is visible LAT cycles after acceptance.
    initial begin : compare
        logic exp_rdy, exp_ov;
        rst_seen = 1'b1;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_rdy = !reset && !flush && ((q.size() < LAT) || out_ready);
            exp_ov  = (q.size() > 0) && ((cyc - q[0].t) >= LAT);
            chk("in_ready", VW'(in_ready), VW'(exp_rdy));
            chk("out_valid", VW'(out_valid), VW'(exp_ov));
            if (rst_seen)
                chk("reset_fields", dut_vec, '0);
            else if (exp_ov)
                chk("fields", dut_vec, model(q[0].a, q[0].b, q[0].sub, q[0].rm));
            if (out_valid && out_ready) n_dut_out++;
            if (reset || flush) begin
                q.delete();
            end else begin
                if (exp_ov && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy)
                    q.push_back('{a: in_a, b: in_b, sub: in_sub, rm: in_rm, t: cyc});
            end
            rst_seen = reset;
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a bundle and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [2:0] rm);
        logic acc;
        in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; in_rm = rm;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
        end
        if (!acc) chk("send_timeout", VW'(0), VW'(1));
    endtask

    task automatic wait_out(output int n);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
    endtask

    int          n, base, seen;
    logic [31:0] va [6] = '{32'h0040_0000, 32'h8000_0000, 32'h807F_FFFF, 32'hBF80_0000, 32'h7FC0_0001, 32'h0080_0000};
    logic [31:0] vb [6] = '{32'h7F80_0000, 32'h7FBF_FFFF, 32'h3F80_0000, 32'h0000_0000, 32'hFF80_0000, 32'h807F_FFFF};
    logic [2:0]  vr [6] = '{3'b100, 3'b001, 3'b101, 3'b011, 3'b110, 3'b010};

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        n_chk = 0; n_err = 0; n_dut_out = 0; cyc = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_rm = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", VW'(in_ready), VW'(1));
        chk("rst_out_valid", VW'(out_valid), VW'(0));
        step();

        // 1.0 - (-2.0)
        send(32'h3F80_0000, 32'hC000_0000, 1'b1, 3'b000);
        in_valid = 1'b0;
        wait_out(n);
        chk("latency", VW'(n), VW'(LAT));
        chk("t1_A", VW'({sign_A, exp_A, sig_A}), VW'({1'b0, 8'h7F, 24'h80_0000}));
        chk("t1_B", VW'({sign_B, exp_B, sig_B}), VW'({1'b1, 8'h80, 24'h80_0000}));
        chk("t1_sub", VW'(sub_op), VW'(1));
        chk("t1_flags", VW'({isZeroA, isInfA, isNaNA, isZeroB, isInfB, isNaNB, isSignaling, rm_invalid}), VW'(0));
        step();

        send(32'h7F80_0001, 32'h7FC0_0000, 1'b0, 3'b000);
        in_valid = 1'b0;
        wait_out(n);
        chk("t2_nan", VW'({isNaNA, isNaNB, isSignaling}), VW'(3'b111));
`ifdef FPU_UNPACK_FCLASS_EN
        chk("t2_class", VW'(class_A), VW'(10'h100));
`endif
        step();

        send(32'h0000_0001, 32'h8000_0000, 1'b0, 3'b000);
        in_valid = 1'b0;
        wait_out(n);
        chk("t3_A", VW'({exp_A, sig_A, isZeroA}), VW'({8'h00, 24'h00_0001, 1'b0}));
        chk("t3_B", VW'({isZeroB, sign_B}), VW'(2'b11));
`ifdef FPU_UNPACK_FCLASS_EN
        chk("t3_class", VW'(class_A), VW'(10'h020));
`endif
        step();

        send(32'hFF80_0000, 32'h3F80_0000, 1'b0, 3'b111);
        in_valid = 1'b0;
        wait_out(n);
        chk("t6_inf", VW'({isInfA, sign_A, rm_invalid, rounding_mode}), VW'({1'b1, 1'b1, 1'b1, 3'b111}));
`ifdef FPU_UNPACK_FCLASS_EN
        chk("t6_class", VW'(class_A), VW'(10'h001));
`endif
        repeat (3) step();

        // Back-pressure: fill with out_ready low, then drain.
        out_ready = 1'b0;
        send(32'h4040_0000, 32'h0000_0000, 1'b0, 3'b001);
        send(32'h4080_0000, 32'h8000_0001, 1'b1, 3'b010);
        in_valid = 1'b1; in_a = 32'h40A0_0000; in_b = 32'h7F80_0000; in_sub = 1'b0; in_rm = 3'b011;
        @(negedge clk);
        chk("full_ready_low", VW'(in_ready), VW'(0));
        chk("stall_fields", dut_vec, model(32'h4040_0000, 32'h0000_0000, 1'b0, 3'b001));
        step();
        @(negedge clk);
        chk("stall_hold", dut_vec, model(32'h4040_0000, 32'h0000_0000, 1'b0, 3'b001));
        step();
        base = n_dut_out;
        out_ready = 1'b1;
        send(32'h40A0_0000, 32'h7F80_0000, 1'b0, 3'b011);
        send(32'h40C0_0000, 32'hFFC0_0000, 1'b1, 3'b100);
        in_valid = 1'b0;
        repeat (6) step();
        chk("stream_count", VW'(n_dut_out - base), VW'(4));

        // Flush while the bundle sits in the first stage.
        send(32'h3F00_0000, 32'h3F00_0000, 1'b0, 3'b000);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_ready", VW'(in_ready), VW'(0));
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_ready", VW'(in_ready), VW'(1));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) seen++;
            step();
            @(negedge clk);
        end
        chk("flush_no_out", VW'(seen), VW'(0));
        step();

        // Offer during flush must not be taken.
        in_valid = 1'b1; in_a = 32'h4000_0000; in_b = 32'h4000_0000; in_sub = 1'b0; in_rm = 3'b000;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        repeat (4) step();

        // Mixed classes streamed back-to-back.
        for (int i = 0; i < 6; i++) send(va[i], vb[i], i[0], vr[i]);
        in_valid = 1'b0;
        repeat (5) step();

        // Reset with bundles in flight.
        out_ready = 1'b0;
        send(32'h4100_0000, 32'h4110_0000, 1'b0, 3'b000);
        send(32'h4120_0000, 32'h4130_0000, 1'b1, 3'b001);
        in_valid = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        base = n_dut_out;
        repeat (4) step();
        chk("reset_drop", VW'(n_dut_out - base), VW'(0));
        chk("model_empty", VW'(q.size()), VW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
